// File: rtl/nmcu_pkg.sv
// Shared NMCU constants and types used by the memory arbiter slice.
package nmcu_pkg;

    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned DATA_WIDTH       = 32;

    // Requesters sharing the cache_system port
    localparam int unsigned NMCU_NUM_MEM_REQ = 2;
    localparam int unsigned REQ_CU           = 0;
    localparam int unsigned REQ_ICN          = 1;

    typedef logic [$clog2(NMCU_NUM_MEM_REQ)-1:0] req_id_t;

    // Arbiter lock state: IDLE arbitrates freely, HOLD pins the stalled grant
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/nmcu_id_fifo.sv
// Synchronous FIFO of requester IDs; pointers carry an extra wrap bit for full/empty.
module nmcu_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage index is the pointer without its wrap bit
    generate
        if (DEPTH > 1) begin : g_idx
            assign wr_idx = wr_ptr_q[IW-1:0];
            assign rd_idx = rd_ptr_q[IW-1:0];
        end else begin : g_idx_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end
    endgenerate

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level == PW'(DEPTH));
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = CW'(level);
    assign rdata_o = mem_q[rd_idx];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ID storage, no reset needed since empty guards reads
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_idx] <= wdata_i;
    end

endmodule

// File: rtl/nmcu_mem_arbiter.sv
// Round-robin arbiter sharing the cache_system port, with in-order response routing.
module nmcu_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_WIDTH      = nmcu_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = nmcu_pkg::DATA_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    input  logic [NUM_REQ-1:0]                    req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_wdata_i,
    output logic [NUM_REQ-1:0]                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]                 resp_rdata_o,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output logic                                  mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]                 mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]                 mem_req_wdata_o,
    input  logic                                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]                 mem_resp_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  err_unexp_resp_o
);

    import nmcu_pkg::*;

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]         locked_idx_q, locked_idx_d;
    logic [IDW-1:0]         grant_idx, scan_off, head_id;
    logic                   grant_valid, scan_found;
    logic [2*NUM_REQ-1:0]   scan_dbl;
    logic [NUM_REQ-1:0]     scan_rot;
    logic                   fire, pop, fifo_full, fifo_empty;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]  resp_rdata_q;
    logic                   err_q;

    // Index addition modulo NUM_REQ
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDW+1)'(NUM_REQ)) s = s - (IDW+1)'(NUM_REQ);
        return s[IDW-1:0];
    endfunction

    // Rotate valids so bit 0 is the rr_ptr requester, then find the first set bit
    assign scan_dbl = {req_valid_i, req_valid_i};
    assign scan_rot = scan_dbl[rr_ptr_q +: NUM_REQ];

    always_comb begin
        scan_found = 1'b0;
        scan_off   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!scan_found && scan_rot[i]) begin
                scan_found = 1'b1;
                scan_off   = IDW'(i);
            end
        end
    end

    // Grant selection and lock FSM next state
    always_comb begin
        state_d      = state_q;
        locked_idx_d = locked_idx_q;
        grant_idx    = wrap_add(rr_ptr_q, scan_off);
        grant_valid  = scan_found & ~fifo_full;
        if (state_q == ARB_HOLD) begin
            grant_idx   = locked_idx_q;
            grant_valid = req_valid_i[locked_idx_q] & ~fifo_full;
        end
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid && !mem_req_ready_i) begin
                    state_d      = ARB_HOLD;
                    locked_idx_d = grant_idx;
                end
            end
            ARB_HOLD: begin
                if (!grant_valid || mem_req_ready_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Zero-latency request path, forced quiet during reset
    always_comb begin
        mem_req_valid_o = rst_n & grant_valid;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;
        req_ready_o     = '0;
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IDW'(i) == grant_idx) begin
                    mem_req_we_o    = req_we_i[i];
                    mem_req_addr_o  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_req_wdata_o = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                    req_ready_o[i]  = grant_valid & mem_req_ready_i;
                end
            end
        end
    end

    assign fire = mem_req_valid_o & mem_req_ready_i;
    assign pop  = mem_resp_valid_i & ~fifo_empty;

    // Round-robin pointer moves past the requester just accepted
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire) rr_ptr_d = wrap_add(grant_idx, IDW'(1));
    end

    // Response strobe goes to the requester at the FIFO head
    always_comb begin
        resp_valid_d = '0;
        if (pop) resp_valid_d = NUM_REQ'(1) << head_id;
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            locked_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            locked_idx_q <= locked_idx_d;
        end
    end

    // Registered response outputs and sticky unexpected-response flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            if (pop) resp_rdata_q <= mem_resp_rdata_i;
            if (mem_resp_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    assign resp_valid_o     = resp_valid_q;
    assign resp_rdata_o     = resp_rdata_q;
    assign err_unexp_resp_o = err_q;

    // In-order record of which requester owns each outstanding request
    nmcu_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fire),
        .wdata_i (grant_idx),
        .pop_i   (pop),
        .rdata_o (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    // A locked requester must keep its request up until accepted
    a_hold_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ARB_HOLD) |-> req_valid_i[locked_idx_q]);

endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// Directed bench for nmcu_mem_arbiter: vector table plus stall/lock and drain sequences.
module tb_nmcu_mem_arbiter;

    import nmcu_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned MO = 4;
    localparam int unsigned OW = $clog2(MO + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     req_we_i;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR*DW-1:0]  req_wdata_i;
    logic [NR-1:0]     resp_valid_o;
    logic [DW-1:0]     resp_rdata_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic              mem_req_we_o;
    logic [AW-1:0]     mem_req_addr_o;
    logic [DW-1:0]     mem_req_wdata_o;
    logic              mem_resp_valid_i;
    logic [DW-1:0]     mem_resp_rdata_i;
    logic [OW-1:0]     outstanding_o;
    logic              err_unexp_resp_o;

    localparam logic [AW-1:0] A0 = 32'h0000_0040;
    localparam logic [AW-1:0] A1 = 32'h0000_0080;
    localparam logic [DW-1:0] W0 = 32'hA0A0_A0A0;
    localparam logic [DW-1:0] W1 = 32'hB1B1_B1B1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nmcu_mem_arbiter #(
        .NUM_REQ         (NR),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .resp_valid_o     (resp_valid_o),
        .resp_rdata_o     (resp_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_rdata_i (mem_resp_rdata_i),
        .outstanding_o    (outstanding_o),
        .err_unexp_resp_o (err_unexp_resp_o)
    );

    typedef struct {
        logic          rst;
        logic [1:0]    v;
        logic          rsp;
        logic [31:0]   rdata;
        logic          mv;
        logic          g;
        logic [1:0]    rdy;
        logic [1:0]    rv;
        logic [31:0]   rd;
        logic [2:0]    outst;
        logic          err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] v, input logic rsp,
                                input logic [31:0] rdata, input logic mv, input logic g,
                                input logic [1:0] rdy, input logic [1:0] rv,
                                input logic [31:0] rd, input logic [2:0] outst, input logic err);
        vec_t t;
        t.rst = rst; t.v = v; t.rsp = rsp; t.rdata = rdata; t.mv = mv; t.g = g;
        t.rdy = rdy; t.rv = rv; t.rd = rd; t.outst = outst; t.err = err;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge and settle before sampling
    task automatic drive(input logic rst, input logic [1:0] v, input logic rdy,
                         input logic rsp, input logic [31:0] rdata);
        @(negedge clk);
        rst_n            = rst;
        req_valid_i      = v;
        mem_req_ready_i  = rdy;
        mem_resp_valid_i = rsp;
        mem_resp_rdata_i = rdata;
        #1;
    endtask

    logic [1:0] drain_rv [3];

    initial begin
        rst_n            = 1'b0;
        req_valid_i      = '0;
        req_we_i         = 2'b10;
        req_addr_i       = {A1, A0};
        req_wdata_i      = {W1, W0};
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = '0;

        //             rst v     rsp rdata          mv g rdy    rv     rd            out err
        vecs.push_back(mk(0, 2'b11, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        1, 0, 2'b01, 2'b00, 32'h0,        0, 0));
        vecs.push_back(mk(1, 2'b00, 1, 32'hDEADBEEF, 0, 0, 2'b00, 2'b00, 32'h0,        1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00, 2'b01, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 1, 2'b10, 2'b00, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h11111111, 1, 0, 2'b01, 2'b00, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h22222222, 1, 1, 2'b10, 2'b10, 32'h11111111, 1, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h33333333, 1, 0, 2'b01, 2'b01, 32'h22222222, 1, 0));
        vecs.push_back(mk(1, 2'b00, 1, 32'h44444444, 0, 0, 2'b00, 2'b10, 32'h33333333, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00, 2'b01, 32'h44444444, 0, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 1, 2'b10, 2'b00, 32'h44444444, 0, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 0, 2'b01, 2'b00, 32'h44444444, 1, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h55555555, 1, 1, 2'b10, 2'b00, 32'h44444444, 2, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 0, 2'b01, 2'b10, 32'h55555555, 2, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 1, 2'b10, 2'b00, 32'h55555555, 3, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h55555555, 4, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h66666666, 0, 0, 2'b00, 2'b00, 32'h55555555, 4, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 0, 2'b01, 2'b01, 32'h66666666, 3, 0));
        vecs.push_back(mk(1, 2'b00, 1, 32'h77777777, 0, 0, 2'b00, 2'b00, 32'h66666666, 4, 0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h0,        0, 0, 2'b00, 2'b10, 32'h77777777, 3, 0));
        vecs.push_back(mk(1, 2'b00, 1, 32'h88888888, 0, 0, 2'b00, 2'b00, 32'h0,        0, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        1, 0, 2'b01, 2'b00, 32'h0,        0, 1));
        vecs.push_back(mk(1, 2'b00, 1, 32'h99999999, 0, 0, 2'b00, 2'b00, 32'h0,        1, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 2'b00, 2'b01, 32'h99999999, 0, 1));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, 1'b1, vecs[i].rsp, vecs[i].rdata);
            check($sformatf("v%0d mem_valid", i), 64'(mem_req_valid_o), 64'(vecs[i].mv));
            check($sformatf("v%0d req_ready", i), 64'(req_ready_o), 64'(vecs[i].rdy));
            check($sformatf("v%0d resp_valid", i), 64'(resp_valid_o), 64'(vecs[i].rv));
            check($sformatf("v%0d resp_rdata", i), 64'(resp_rdata_o), 64'(vecs[i].rd));
            check($sformatf("v%0d outstanding", i), 64'(outstanding_o), 64'(vecs[i].outst));
            check($sformatf("v%0d err", i), 64'(err_unexp_resp_o), 64'(vecs[i].err));
            if (vecs[i].mv) begin
                check($sformatf("v%0d addr", i), 64'(mem_req_addr_o), vecs[i].g ? 64'(A1) : 64'(A0));
                check($sformatf("v%0d wdata", i), 64'(mem_req_wdata_o), vecs[i].g ? 64'(W1) : 64'(W0));
                check($sformatf("v%0d we", i), 64'(mem_req_we_o), 64'(vecs[i].g));
            end
        end

        // Stall/lock: rr_ptr is moved to 0 first so req0 would win without the lock
        drive(1, 2'b10, 1, 0, 0);
        check("lk0 mem_valid", 64'(mem_req_valid_o), 64'd1);
        check("lk0 addr", 64'(mem_req_addr_o), 64'(A1));
        check("lk0 ready", 64'(req_ready_o), 64'b10);
        drive(1, 2'b10, 0, 0, 0);
        check("lk1 mem_valid", 64'(mem_req_valid_o), 64'd1);
        check("lk1 addr", 64'(mem_req_addr_o), 64'(A1));
        check("lk1 ready", 64'(req_ready_o), 64'b00);
        for (int k = 2; k <= 3; k++) begin
            drive(1, 2'b11, 0, 0, 0);
            check($sformatf("lk%0d addr", k), 64'(mem_req_addr_o), 64'(A1));
            check($sformatf("lk%0d ready", k), 64'(req_ready_o), 64'b00);
        end
        drive(1, 2'b11, 1, 0, 0);
        check("lk4 addr", 64'(mem_req_addr_o), 64'(A1));
        check("lk4 ready", 64'(req_ready_o), 64'b10);
        drive(1, 2'b01, 1, 0, 0);
        check("lk5 addr", 64'(mem_req_addr_o), 64'(A0));
        check("lk5 ready", 64'(req_ready_o), 64'b01);
        drive(1, 2'b00, 1, 0, 0);
        check("lk6 outstanding", 64'(outstanding_o), 64'd3);

        // Drain in issue order: req1, req1, req0
        drain_rv = '{2'b10, 2'b10, 2'b01};
        for (int k = 0; k < 3; k++) begin
            drive(1, 2'b00, 1, 1, 32'hC0DE_0000 + 32'(k));
            drive(1, 2'b00, 1, 0, 0);
            check($sformatf("dr%0d resp_valid", k), 64'(resp_valid_o), 64'(drain_rv[k]));
            check($sformatf("dr%0d resp_rdata", k), 64'(resp_rdata_o), 64'(32'hC0DE_0000 + 32'(k)));
        end
        check("dr outstanding", 64'(outstanding_o), 64'd0);
        check("dr err sticky", 64'(err_unexp_resp_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
